// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: bus widths, FSM and owner
// encodings, and the fixed-priority-with-starvation-override grant function.
package mem_port_arbiter_pkg;

   localparam int ADDR_LEN  = 32;
   localparam int DATA_LEN  = 32;
   localparam int INSTR_LEN = 32;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_DONE  = 2'd3
   } arb_state_t;

   typedef enum logic {
      ARB_OWN_IF = 1'b0,
      ARB_OWN_DM = 1'b1
   } arb_owner_t;

   typedef struct packed {
      logic       valid;
      arb_owner_t owner;
   } arb_grant_t;

   // Data stage normally wins because it carries the older instruction; a
   // starved fetch overrides that once the data streak has saturated.
   function automatic arb_grant_t arbitrate(input logic if_cand,
                                            input logic dm_cand,
                                            input logic starved);
      arb_grant_t g;
      g.valid = if_cand | dm_cand;
      g.owner = (dm_cand && !(starved && if_cand)) ? ARB_OWN_DM : ARB_OWN_IF;
      return g;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter timing the fixed memory latency; saturates at zero.
module arb_lat_counter #(
   parameter int MEM_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero,
   output logic last
);

   localparam int CW = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (dec && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign zero = (count == '0);
   // last: the decrement happening this cycle brings the count to zero
   assign last = (count == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory stages:
// one access in flight, fixed latency, one-cycle acks, flushable fetches.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_req,
   input  logic [ADDR_LEN-1:0]  if_addr,
   input  logic                 if_flush,
   output logic                 if_ack,
   output logic [INSTR_LEN-1:0] if_rdata,
   input  logic                 dm_req,
   input  logic                 dm_we,
   input  logic [ADDR_LEN-1:0]  dm_addr,
   input  logic [DATA_LEN-1:0]  dm_wdata,
   output logic                 dm_ack,
   output logic [DATA_LEN-1:0]  dm_rdata,
   output logic                 stall_if,
   output logic                 stall_mem,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_LEN-1:0]  mem_addr,
   output logic [DATA_LEN-1:0]  mem_wdata,
   input  logic [DATA_LEN-1:0]  mem_rdata
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   arb_state_t    state;
   arb_owner_t    owner;
   logic [SW-1:0] streak;
   logic          flushed;

   logic       in_done;
   logic       arb_open;
   logic       if_cand;
   logic       dm_cand;
   logic       starved;
   logic       flush_hit;
   arb_grant_t grant;
   logic       lat_load;
   logic       lat_dec;
   logic       lat_zero;
   logic       lat_last;

   assign in_done  = (state == ARB_DONE);
   assign arb_open = (state == ARB_IDLE) || in_done;

   // In DONE the finishing requester still holds req this cycle, so it is
   // masked to avoid re-granting the access that is just completing.
   assign if_cand  = if_req & ~if_flush & ~(in_done & (owner == ARB_OWN_IF));
   assign dm_cand  = dm_req & ~(in_done & (owner == ARB_OWN_DM));
   assign starved  = (streak == SW'(STARVE_MAX));
   assign grant    = arbitrate(if_cand, dm_cand, starved);

   assign flush_hit = if_flush & (owner == ARB_OWN_IF);

   assign lat_load = (state == ARB_ISSUE);
   assign lat_dec  = (state == ARB_WAIT);

   arb_lat_counter #(
      .MEM_LAT (MEM_LAT)
   ) u_lat (
      .clk  (clk),
      .rst  (rst),
      .load (lat_load),
      .dec  (lat_dec),
      .zero (lat_zero),
      .last (lat_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ARB_IDLE;
         owner     <= ARB_OWN_DM;
         flushed   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= 1'b0;
         case (state)
            ARB_IDLE, ARB_DONE: begin
               if (grant.valid) begin
                  state   <= ARB_ISSUE;
                  owner   <= grant.owner;
                  flushed <= 1'b0;
                  mem_en  <= 1'b1;
                  if (grant.owner == ARB_OWN_DM) begin
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                  end
               end else begin
                  state <= ARB_IDLE;
               end
            end
            ARB_ISSUE: begin
               state <= (MEM_LAT == 1) ? ARB_DONE : ARB_WAIT;
               if (flush_hit) flushed <= 1'b1;
            end
            ARB_WAIT: begin
               if (lat_last || lat_zero) state <= ARB_DONE;
               if (flush_hit) flushed <= 1'b1;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // Counts data grants that bypassed a waiting fetch; any idle-fetch cycle resets it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak <= '0;
      end else if (!if_req) begin
         streak <= '0;
      end else if (arb_open && grant.valid) begin
         if (grant.owner == ARB_OWN_IF) begin
            streak <= '0;
         end else if (!starved) begin
            streak <= streak + SW'(1);
         end
      end
   end

   assign if_ack    = in_done & (owner == ARB_OWN_IF) & ~flushed & ~if_flush;
   assign dm_ack    = in_done & (owner == ARB_OWN_DM);
   assign if_rdata  = if_ack ? mem_rdata[INSTR_LEN-1:0] : '0;
   assign dm_rdata  = dm_ack ? mem_rdata : '0;
   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = dm_req & ~dm_ack;

endmodule
